// File: rtl/pspin_stdout_arb_pkg.sv
// Shared types and constants for the PsPIN stdout arbiter and its FIFO.
package pspin_stdout_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_CNT_W      = 16;
  localparam int DEFAULT_FIFO_DEPTH = 64;

  // Width needed to index 'value' items, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/pspin_stdout_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy output.
// While empty, rdata keeps showing the last word that was popped.
module pspin_stdout_fifo
  import pspin_stdout_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = DEFAULT_FIFO_DEPTH,
  parameter int LEVEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [LEVEL_W-1:0]    level
);

  localparam int ADDR_W = clog2_min1(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [LEVEL_W-1:0]    count;
  logic [DATA_WIDTH-1:0] hold_q;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == LEVEL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage array; no reset needed because empty masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and the last-popped word shown while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = empty ? hold_q : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/pspin_stdout_arb.sv
// Merges per-cluster printf word streams into one stdout FIFO.
// Round-robin grant held for a whole message; a watchdog frees a stalled lock.
module pspin_stdout_arb
  import pspin_stdout_arb_pkg::*;
#(
  parameter int NUM_CLUSTERS   = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_CLUSTERS-1:0]            cl_wr_valid,
  input  logic [NUM_CLUSTERS*DATA_WIDTH-1:0] cl_wr_data,
  input  logic [NUM_CLUSTERS-1:0]            cl_wr_last,
  output logic [NUM_CLUSTERS-1:0]            cl_wr_ready,
  input  logic                               stdout_rd_en,
  output logic [DATA_WIDTH-1:0]              stdout_dout,
  output logic                               stdout_data_valid,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level_o,
  output logic                               timeout_o,
  output logic [TIMEOUT_CNT_W-1:0]           timeout_cnt_o
);

  localparam int GRANT_W = clog2_min1(NUM_CLUSTERS);
  localparam int WD_W    = clog2_min1(TIMEOUT_CYCLES);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [WD_W-1:0]    WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(NUM_CLUSTERS - 1);

  arb_state_e                state_q, state_d;
  logic [GRANT_W-1:0]        grant_q, grant_d;
  logic [GRANT_W-1:0]        rr_q, rr_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic                      release_d;
  logic                      timeout_q;
  logic [TIMEOUT_CNT_W-1:0]  tcnt_q;

  logic                      arb_found;
  logic [GRANT_W-1:0]        arb_idx;
  logic [GRANT_W-1:0]        cand;
  logic [GRANT_W-1:0]        grant_next_rr;

  logic                      sel_valid;
  logic                      sel_last;
  logic [DATA_WIDTH-1:0]     sel_data;
  logic                      accept;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic [LEVEL_W-1:0]        fifo_level;

  assign sel_valid     = cl_wr_valid[grant_q];
  assign sel_last      = cl_wr_last[grant_q];
  assign sel_data      = cl_wr_data[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign accept        = (state_q == ST_LOCKED) && sel_valid && !fifo_full;
  assign grant_next_rr = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  // Round-robin scan: first requesting cluster starting at rr_q.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NUM_CLUSTERS; i++) begin
      cand = GRANT_W'((int'(rr_q) + i) % NUM_CLUSTERS);
      if (!arb_found && cl_wr_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Arbiter next state, readies, watchdog and forced release.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    wd_d        = wd_q;
    release_d   = 1'b0;
    cl_wr_ready = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          grant_d = arb_idx;
          wd_d    = '0;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        cl_wr_ready[grant_q] = !fifo_full;
        if (accept) begin
          wd_d = '0;
          if (sel_last) begin
            rr_d    = grant_next_rr;
            state_d = ST_IDLE;
          end
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wd_q == WD_LIMIT) begin
            wd_d      = '0;
            rr_d      = grant_next_rr;
            release_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

  // Forced-release pulse and saturating release counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
      tcnt_q    <= '0;
    end else begin
      timeout_q <= release_d;
      if (release_d && (tcnt_q != '1)) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
    end
  end

  pspin_stdout_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .LEVEL_W    (LEVEL_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (sel_data),
    .pop   (stdout_rd_en),
    .rdata (stdout_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign stdout_data_valid = !fifo_empty;
  assign fifo_level_o      = fifo_level;
  assign timeout_o         = timeout_q;
  assign timeout_cnt_o     = tcnt_q;

endmodule

// File: tb/tb_pspin_stdout_arb.sv
// Self-checking bench for pspin_stdout_arb: a message-level model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pspin_stdout_arb;

  localparam int NCL   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 64;
  localparam int TMO   = 16;
  localparam int LW    = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [NCL-1:0]    cl_wr_valid;
  logic [NCL*DW-1:0] cl_wr_data;
  logic [NCL-1:0]    cl_wr_last;
  logic [NCL-1:0]    cl_wr_ready;
  logic              stdout_rd_en;
  logic [DW-1:0]     stdout_dout;
  logic              stdout_data_valid;
  logic [LW-1:0]     fifo_level_o;
  logic              timeout_o;
  logic [15:0]       timeout_cnt_o;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;

  // Per-cluster word sources: {last, data}; head is what the cluster offers.
  logic [DW:0]   srcQ [NCL][$];
  logic [DW-1:0] popped [$];
  int            acceptCyc [NCL];

  // Model: FIFO contents, current owner (-1 = none), next start, idle run.
  bit [DW-1:0]   mq [$];
  int            mOwner;
  int            mRr;
  int            mIdle;
  int            mCount;
  bit            mPulse;
  bit [DW-1:0]   mHold;
  bit            modelValid = 1'b0;
  logic [NCL-1:0] expReady;

  pspin_stdout_arb #(
    .NUM_CLUSTERS   (NCL),
    .DATA_WIDTH     (DW),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cl_wr_valid       (cl_wr_valid),
    .cl_wr_data        (cl_wr_data),
    .cl_wr_last        (cl_wr_last),
    .cl_wr_ready       (cl_wr_ready),
    .stdout_rd_en      (stdout_rd_en),
    .stdout_dout       (stdout_dout),
    .stdout_data_valid (stdout_data_valid),
    .fifo_level_o      (fifo_level_o),
    .timeout_o         (timeout_o),
    .timeout_cnt_o     (timeout_cnt_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: simulation did not finish, want finish");
    $fatal(1, "[TB] time limit");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mOwner     = -1;
    mRr        = 0;
    mIdle      = 0;
    mCount     = 0;
    mPulse     = 1'b0;
    mHold      = '0;
    modelValid = 1'b1;
  endtask

  // One clock of the rules: owner streams until last word or TMO idle cycles.
  task automatic modelAdvance();
    int          sz  = mq.size();
    bit          acc = 1'b0;
    bit          lst = 1'b0;
    bit [DW-1:0] w   = '0;
    mPulse = 1'b0;
    if (mOwner >= 0 && cl_wr_valid[mOwner] === 1'b1 && sz < DEPTH) begin
      acc = 1'b1;
      w   = cl_wr_data[mOwner*DW +: DW];
      lst = cl_wr_last[mOwner];
    end
    if (stdout_rd_en && sz > 0) mHold = mq.pop_front();
    if (acc) mq.push_back(w);
    if (mOwner < 0) begin
      for (int k = 0; k < NCL; k++) begin
        if (mOwner < 0 && cl_wr_valid[(mRr + k) % NCL] === 1'b1) begin
          mOwner = (mRr + k) % NCL;
          mIdle  = 0;
        end
      end
    end else if (acc) begin
      mIdle = 0;
      if (lst) begin
        mRr    = (mOwner + 1) % NCL;
        mOwner = -1;
      end
    end else begin
      mIdle++;
      if (mIdle == TMO) begin
        mRr    = (mOwner + 1) % NCL;
        mOwner = -1;
        mIdle  = 0;
        mPulse = 1'b1;
        if (mCount < 65535) mCount++;
      end
    end
  endtask

  // Compare every output against the model, then step the model.
  always @(negedge clk) begin
    if (modelValid) begin
      for (int i = 0; i < NCL; i++) expReady[i] = (mOwner == i) && (mq.size() < DEPTH);
      checkOutput("cl_wr_ready", cl_wr_ready, expReady);
      checkOutput("stdout_data_valid", stdout_data_valid, mq.size() > 0);
      checkOutput("stdout_dout", stdout_dout, (mq.size() > 0) ? mq[0] : mHold);
      checkOutput("fifo_level_o", fifo_level_o, mq.size());
      checkOutput("timeout_o", timeout_o, mPulse);
      checkOutput("timeout_cnt_o", timeout_cnt_o, mCount);
    end
    if (rst) modelReset();
    else if (modelValid) modelAdvance();
  end

  task automatic driveSources();
    for (int i = 0; i < NCL; i++) begin
      if (srcQ[i].size() > 0) begin
        cl_wr_valid[i]           = 1'b1;
        cl_wr_data[i*DW +: DW]   = srcQ[i][0][DW-1:0];
        cl_wr_last[i]            = srcQ[i][0][DW];
      end else begin
        cl_wr_valid[i]           = 1'b0;
        cl_wr_data[i*DW +: DW]   = '0;
        cl_wr_last[i]            = 1'b0;
      end
    end
  endtask

  // One clock: rd_en for this cycle, then retire handshaken words.
  task automatic applyStimulus(input bit rd);
    logic [NCL-1:0] hs;
    logic           rstSnap;
    logic [DW:0]    tmp;
    stdout_rd_en = rd;
    @(negedge clk);
    hs      = cl_wr_valid & cl_wr_ready;
    rstSnap = rst;
    if (rd && stdout_data_valid && !rstSnap) popped.push_back(stdout_dout);
    @(posedge clk);
    #1;
    if (!rstSnap) begin
      for (int i = 0; i < NCL; i++) begin
        if (hs[i] && srcQ[i].size() > 0) begin
          tmp          = srcQ[i].pop_front();
          acceptCyc[i] = cyc;
        end
      end
    end
    stdout_rd_en = 1'b0;
    driveSources();
  endtask

  task automatic resetDut(input int n);
    rst = 1'b1;
    for (int i = 0; i < NCL; i++) srcQ[i].delete();
    driveSources();
    repeat (n) applyStimulus(1'b0);
    rst = 1'b0;
    popped.delete();
  endtask

  task automatic drain(input string tag, input int budget);
    int b = 0;
    while ((srcQ[0].size() > 0 || srcQ[1].size() > 0 || stdout_data_valid) && b < budget) begin
      applyStimulus(1'b1);
      b++;
    end
    checkOutput({tag, "_drained_in_budget"}, b < budget, 1'b1);
  endtask

  initial begin
    int b;
    int seen;
    int bad;
    logic [DW-1:0] exp3 [12];

    rst          = 1'b1;
    stdout_rd_en = 1'b0;
    cl_wr_valid  = '0;
    cl_wr_data   = '0;
    cl_wr_last   = '0;
    resetDut(2);

    // Scenario 1: reset mid-message clears everything; next grant from cluster 0.
    srcQ[0].push_back({1'b1, 32'h11});
    srcQ[1].push_back({1'b0, 32'h21});
    srcQ[1].push_back({1'b0, 32'h22});
    srcQ[1].push_back({1'b1, 32'h23});
    driveSources();
    for (b = 0; b < 50 && srcQ[1].size() > 2; b++) applyStimulus(1'b0);
    checkOutput("t1_prereset_level", fifo_level_o, 2);
    checkOutput("t1_prereset_dout", stdout_dout, 32'h11);
    resetDut(3);
    checkOutput("t1_reset_ready", cl_wr_ready, 2'b00);
    checkOutput("t1_reset_valid", stdout_data_valid, 1'b0);
    checkOutput("t1_reset_dout", stdout_dout, 32'h0);
    checkOutput("t1_reset_level", fifo_level_o, 0);
    checkOutput("t1_reset_timeout", {timeout_o, timeout_cnt_o}, 17'h0);
    srcQ[0].push_back({1'b1, 32'h31});
    srcQ[1].push_back({1'b1, 32'h41});
    driveSources();
    applyStimulus(1'b0);
    checkOutput("t1_first_grant_c0", cl_wr_ready, 2'b01);
    drain("t1", 50);
    checkOutput("t1_pop_count", popped.size(), 2);
    if (popped.size() == 2) begin
      checkOutput("t1_pop0", popped[0], 32'h31);
      checkOutput("t1_pop1", popped[1], 32'h41);
    end

    // Scenario 2: single two-word message, readies after the arbitration bubble.
    popped.delete();
    srcQ[0].push_back({1'b0, 32'hA1});
    srcQ[0].push_back({1'b1, 32'hA2});
    driveSources();
    checkOutput("t2_bubble_ready", cl_wr_ready, 2'b00);
    applyStimulus(1'b0);
    checkOutput("t2_ready_after_grant", cl_wr_ready, 2'b01);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("t2_ready_after_last", cl_wr_ready, 2'b00);
    checkOutput("t2_level2", fifo_level_o, 2);
    checkOutput("t2_head_a1", stdout_dout, 32'hA1);
    applyStimulus(1'b1);
    checkOutput("t2_head_a2", stdout_dout, 32'hA2);
    checkOutput("t2_level1", fifo_level_o, 1);
    applyStimulus(1'b1);
    checkOutput("t2_level0", fifo_level_o, 0);
    checkOutput("t2_empty", stdout_data_valid, 1'b0);

    // Scenario 3: contention, messages alternate c0, c1, c0, c1 without interleave.
    resetDut(2);
    for (int m = 0; m < 2; m++) begin
      for (int w = 0; w < 3; w++) begin
        srcQ[0].push_back({w == 2, 32'h100 + 32'(m*3 + w + 1)});
        srcQ[1].push_back({w == 2, 32'h200 + 32'(m*3 + w + 1)});
      end
    end
    exp3 = '{32'h101, 32'h102, 32'h103, 32'h201, 32'h202, 32'h203,
             32'h104, 32'h105, 32'h106, 32'h204, 32'h205, 32'h206};
    driveSources();
    drain("t3", 100);
    checkOutput("t3_pop_count", popped.size(), 12);
    for (int k = 0; k < 12; k++) begin
      if (k < popped.size()) checkOutput($sformatf("t3_order_%0d", k), popped[k], exp3[k]);
    end

    // Scenario 4: fill to full without popping, then drain; nothing lost or duplicated.
    popped.delete();
    for (int k = 0; k < DEPTH + 4; k++) srcQ[0].push_back({k == DEPTH + 3, 32'h4000 + 32'(k)});
    driveSources();
    for (b = 0; b < 200 && fifo_level_o != LW'(DEPTH); b++) applyStimulus(1'b0);
    checkOutput("t4_full_level", fifo_level_o, DEPTH);
    checkOutput("t4_full_ready", cl_wr_ready, 2'b00);
    repeat (3) applyStimulus(1'b0);
    checkOutput("t4_stall_level", fifo_level_o, DEPTH);
    checkOutput("t4_stall_left", srcQ[0].size(), 4);
    applyStimulus(1'b1);
    checkOutput("t4_after_pop_level", fifo_level_o, DEPTH - 1);
    checkOutput("t4_after_pop_ready", cl_wr_ready, 2'b01);
    drain("t4", 300);
    checkOutput("t4_pop_count", popped.size(), DEPTH + 4);
    bad = 0;
    for (int k = 0; k < DEPTH + 4; k++) begin
      if (k >= popped.size() || popped[k] !== 32'h4000 + 32'(k)) bad++;
    end
    checkOutput("t4_order_errors", bad, 0);

    // Scenario 5: cluster 1 stalls mid-message; watchdog frees it for cluster 0.
    popped.delete();
    srcQ[1].push_back({1'b0, 32'h501});
    driveSources();
    for (b = 0; b < 20 && srcQ[1].size() > 0; b++) applyStimulus(1'b0);
    srcQ[0].push_back({1'b1, 32'h601});
    driveSources();
    seen = -1;
    for (int k = 0; k < 40 && seen < 0; k++) begin
      applyStimulus(1'b0);
      if (timeout_o) seen = cyc - acceptCyc[1];
    end
    checkOutput("t5_release_delay", seen, TMO);
    checkOutput("t5_timeout_cnt", timeout_cnt_o, 1);
    applyStimulus(1'b0);
    checkOutput("t5_pulse_one_cycle", timeout_o, 1'b0);
    checkOutput("t5_c0_granted", cl_wr_ready, 2'b01);
    drain("t5", 50);
    checkOutput("t5_pop_count", popped.size(), 2);
    if (popped.size() == 2) begin
      checkOutput("t5_pop0", popped[0], 32'h501);
      checkOutput("t5_pop1", popped[1], 32'h601);
    end

    // Scenario 6: push and pop together at level 1, then pops on empty.
    srcQ[0].push_back({1'b1, 32'h61});
    driveSources();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("t6_level1", fifo_level_o, 1);
    srcQ[0].push_back({1'b1, 32'h62});
    driveSources();
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("t6_pushpop_level", fifo_level_o, 1);
    checkOutput("t6_pushpop_head", stdout_dout, 32'h62);
    applyStimulus(1'b1);
    checkOutput("t6_pop_level0", fifo_level_o, 0);
    applyStimulus(1'b1);
    checkOutput("t6_empty_pop_level", fifo_level_o, 0);
    checkOutput("t6_empty_hold_dout", stdout_dout, 32'h62);
    checkOutput("t6_empty_valid", stdout_data_valid, 1'b0);

    applyStimulus(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
